write_buffer: RTL
=================

WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, byte address width.
REQ-002 Parameter BLOCK_WIDTH, default 32, data width of one entry.
REQ-003 Parameter DEPTH_log, default 2, log2 of the entry count (DEPTH = 4).
REQ-004 Parameter DATA_NUMBER_BYTES_log, default 2, low address bits ignored in every address compare.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 wr_enable  in  1  processor store request.
REQ-008 wr_address  in  ADDRESS_WIDTH  store address.
REQ-009 wr_data  in  BLOCK_WIDTH  store data.
REQ-010 wr_accept  out  1  store taken this cycle (combinational).
REQ-011 lookup_address  in  ADDRESS_WIDTH  read-miss address from the read FSM.
REQ-012 buffer_address_exist  out  1  lookup hit (combinational).
REQ-013 buffer_data_found  out  BLOCK_WIDTH  hit data; zero when no hit.
REQ-014 mem_read_busy  in  1  read FSM owns memory; drain start is blocked.
REQ-015 mem_wr_enable  out  1  drain request to memory, held until mem_wr_done.
REQ-016 mem_wr_address  out  ADDRESS_WIDTH  drain address (head entry).
REQ-017 mem_wr_data  out  BLOCK_WIDTH  drain data (head entry).
REQ-018 mem_wr_done  in  1  memory completed the write this cycle.
REQ-019 full  out  1  count == DEPTH.
REQ-020 empty  out  1  count == 0.
REQ-021 count  out  DEPTH_log+1  number of valid entries.

Function
REQ-022 Entries: circular FIFO of DEPTH slots {valid, address, data}; head/tail pointers of DEPTH_log bits, wrap modulo DEPTH.
REQ-023 Match: address bits [ADDRESS_WIDTH-1:DATA_NUMBER_BYTES_log] equal and entry valid.
REQ-024 Coalesce: wr_enable with a match to a valid entry not currently being drained -> overwrite that entry's data, count unchanged, wr_accept=1.
REQ-025 Allocate: wr_enable, no coalescible match, full=0 -> write at tail, tail+1, count+1, wr_accept=1.
REQ-026 Reject: wr_enable, no coalescible match, full=1 -> wr_accept=0, no state change; a same-cycle mem_wr_done does not free the slot for this request.
REQ-027 Lookup: on multiple matches, return youngest entry (nearest tail); lookup reflects state before any same-cycle write.
REQ-028 FSM states: IDLE, DRAIN.
REQ-029 IDLE -> DRAIN when empty=0 and mem_read_busy=0; mem_wr_enable=1 from the cycle DRAIN is entered.
REQ-030 DRAIN: mem_wr_enable=1, address/data from head, stable until done; mem_read_busy ignored once in DRAIN.
REQ-031 DRAIN with mem_wr_done=1: clear head valid, head+1, count-1, mem_wr_enable=0 next cycle, return to IDLE (one idle cycle minimum between drains).
REQ-032 Simultaneous allocate and drain-complete: count unchanged, both pointers advance.
REQ-033 Head entry under DRAIN is not coalescible; a matching store allocates a new entry.
REQ-034 mem_wr_done outside DRAIN is ignored.
REQ-035 Outputs when idle: mem_wr_enable=0, mem_wr_address=0, mem_wr_data=0.

Reset
REQ-036 rst=1 immediately: state IDLE, head=tail=0, all valid=0, count=0, empty=1, full=0, mem_wr_enable=0, mem_wr_address=0, mem_wr_data=0, buffer_address_exist=0.
REQ-037 Reset during DRAIN discards all entries; no completion is expected afterwards.

Verification
REQ-038 Store 0x100/0xAAAA, mem_read_busy=1 -> wr_accept=1, count=1, lookup 0x102 -> exist=1, data 0xAAAA, no drain.
REQ-039 Four stores 0x10,0x14,0x18,0x1C, busy=1, then store 0x20 -> full=1, wr_accept=0; store 0x14/0x55 -> coalesced, wr_accept=1, lookup 0x14 -> 0x55.
REQ-040 busy=0 with one entry 0x40/0x7, done after 3 cycles -> mem_wr_enable high 3 cycles with 0x40/0x7, then count=0, empty=1.
REQ-041 Head 0x40 draining, store 0x40/0x9 -> new entry, count=2, lookup 0x40 -> 0x9; after drain, next drain writes 0x40/0x9.
REQ-042 Full buffer, store and mem_wr_done same cycle -> wr_accept=0, count=3 next cycle.
REQ-043 Assert rst mid-DRAIN -> mem_wr_enable=0 and count=0 without a clock edge.

Source files
------------

// File: rtl/write_buffer_if.sv
// Store-side, lookup and memory-drain signals of the write buffer, bundled for port use.
interface write_buffer_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BLOCK_WIDTH   = 32,
    parameter int DEPTH_log     = 2
);
    logic                     wr_enable;
    logic [ADDRESS_WIDTH-1:0] wr_address;
    logic [BLOCK_WIDTH-1:0]   wr_data;
    logic                     wr_accept;
    logic [ADDRESS_WIDTH-1:0] lookup_address;
    logic                     buffer_address_exist;
    logic [BLOCK_WIDTH-1:0]   buffer_data_found;
    logic                     mem_read_busy;
    logic                     mem_wr_enable;
    logic [ADDRESS_WIDTH-1:0] mem_wr_address;
    logic [BLOCK_WIDTH-1:0]   mem_wr_data;
    logic                     mem_wr_done;
    logic                     full;
    logic                     empty;
    logic [DEPTH_log:0]       count;

    modport slave (
        input  wr_enable, wr_address, wr_data, lookup_address, mem_read_busy, mem_wr_done,
        output wr_accept, buffer_address_exist, buffer_data_found,
               mem_wr_enable, mem_wr_address, mem_wr_data, full, empty, count
    );

    modport master (
        output wr_enable, wr_address, wr_data, lookup_address, mem_read_busy, mem_wr_done,
        input  wr_accept, buffer_address_exist, buffer_data_found,
               mem_wr_enable, mem_wr_address, mem_wr_data, full, empty, count
    );
endinterface

// File: rtl/write_buffer.sv
// Coalescing store buffer: a small circular FIFO of pending stores that is
// drained to memory one entry at a time whenever the read path is not using it.
// Stores to an address already buffered overwrite the buffered data, except the
// entry currently being written out, which must stay stable until completion.
module write_buffer #(
    parameter int ADDRESS_WIDTH         = 32,
    parameter int BLOCK_WIDTH           = 32,
    parameter int DEPTH_log             = 2,
    parameter int DATA_NUMBER_BYTES_log = 2
) (
    input  logic          clk,
    input  logic          rst,
    write_buffer_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_log;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [DEPTH-1:0]         valid_r;
    logic [ADDRESS_WIDTH-1:0] addr_r [DEPTH];
    logic [BLOCK_WIDTH-1:0]   data_r [DEPTH];
    logic [DEPTH_log-1:0]     head_r;
    logic [DEPTH_log-1:0]     tail_r;
    logic [DEPTH_log:0]       count_r;

    logic                     full_s;
    logic                     empty_s;
    logic                     draining_s;
    logic                     done_s;
    logic                     alloc_s;
    logic                     coal_wr_s;
    logic                     hit_s;
    logic [DEPTH_log-1:0]     hit_idx_s;
    logic                     coal_s;
    logic [DEPTH_log-1:0]     coal_idx_s;
    logic [DEPTH_log-1:0]     slot_s;
    logic                     hit_now_s;
    logic                     coal_now_s;

    // Addresses are compared at block granularity; byte-offset bits are ignored.
    function automatic logic addr_match(input logic [ADDRESS_WIDTH-1:0] a,
                                        input logic [ADDRESS_WIDTH-1:0] b);
        return a[ADDRESS_WIDTH-1:DATA_NUMBER_BYTES_log] == b[ADDRESS_WIDTH-1:DATA_NUMBER_BYTES_log];
    endfunction

    assign full_s     = (count_r == (DEPTH_log+1)'(DEPTH));
    assign empty_s    = (count_r == (DEPTH_log+1)'(0));
    assign draining_s = (state_r == DRAIN);
    assign done_s     = draining_s && bus.mem_wr_done;
    assign coal_wr_s  = bus.wr_enable && coal_s;
    // Full is judged on the registered count, so a same-cycle drain completion never frees a slot early.
    assign alloc_s    = bus.wr_enable && !coal_s && !full_s;

    // Scan entries oldest to youngest so the last match found is the youngest one.
    always_comb begin
        hit_s      = 1'b0;
        hit_idx_s  = '0;
        coal_s     = 1'b0;
        coal_idx_s = '0;
        slot_s     = '0;
        hit_now_s  = 1'b0;
        coal_now_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            slot_s     = head_r + DEPTH_log'(k);
            hit_now_s  = valid_r[slot_s] && addr_match(addr_r[slot_s], bus.lookup_address);
            coal_now_s = valid_r[slot_s] && addr_match(addr_r[slot_s], bus.wr_address)
                         && !(draining_s && (slot_s == head_r));
            hit_s      = hit_s | hit_now_s;
            hit_idx_s  = hit_now_s ? slot_s : hit_idx_s;
            coal_s     = coal_s | coal_now_s;
            coal_idx_s = coal_now_s ? slot_s : coal_idx_s;
        end
    end

    assign bus.wr_accept            = bus.wr_enable && (coal_s || !full_s);
    assign bus.buffer_address_exist = hit_s;
    assign bus.buffer_data_found    = hit_s ? data_r[hit_idx_s] : '0;
    assign bus.mem_wr_enable        = draining_s;
    assign bus.mem_wr_address       = draining_s ? addr_r[head_r] : '0;
    assign bus.mem_wr_data          = draining_s ? data_r[head_r] : '0;
    assign bus.full                 = full_s;
    assign bus.empty                = empty_s;
    assign bus.count                = count_r;

    // Drain controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Start a drain when entries wait and memory is free; finish on completion.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!empty_s && !bus.mem_read_busy) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DRAIN: begin
                if (bus.mem_wr_done) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Entry storage, pointers and occupancy: coalesce, allocate at tail, retire head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= '0;
                data_r[i] <= '0;
            end
        end else begin
            if (coal_wr_s) begin
                data_r[coal_idx_s] <= bus.wr_data;
            end
            if (alloc_s) begin
                valid_r[tail_r] <= 1'b1;
                addr_r[tail_r]  <= bus.wr_address;
                data_r[tail_r]  <= bus.wr_data;
                tail_r          <= tail_r + DEPTH_log'(1);
            end
            if (done_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + DEPTH_log'(1);
            end
            case ({alloc_s, done_s})
                2'b10:   count_r <= count_r + (DEPTH_log+1)'(1);
                2'b01:   count_r <= count_r - (DEPTH_log+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule
